// File: rtl/hl_io_bank_ctrl.sv
// Controller for a bank of high-level west-side IO slices: per-pad config registers,
// counted power-up hold, glitch-free reconfiguration of driving pads, registered TX/RX paths.
module hl_io_bank_ctrl #(
    parameter int NUM_PADS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int PWRUP_CYCLES = 16,
    parameter int CFG_AW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_AW-1:0]   cfg_addr,
    input  logic [7:0]          cfg_data,
    output logic                cfg_err,
    output logic                pwrup_done,
    input  logic [NUM_PADS-1:0] tx_data,
    input  logic [NUM_PADS-1:0] tx_oe,
    output logic [NUM_PADS-1:0] rx_data,
    input  logic [NUM_PADS-1:0] outi,
    output logic [NUM_PADS-1:0] dq,
    output logic [NUM_PADS-1:0] enq,
    output logic [NUM_PADS-1:0] enabq,
    output logic [NUM_PADS-1:0] drv0,
    output logic [NUM_PADS-1:0] drv1,
    output logic [NUM_PADS-1:0] drv2,
    output logic [NUM_PADS-1:0] prg_slew,
    output logic [NUM_PADS-1:0] puq,
    output logic [NUM_PADS-1:0] pd,
    output logic [NUM_PADS-1:0] ppen,
    output logic [NUM_PADS-1:0] pwrupzhl,
    output logic [NUM_PADS-1:0] pwrup_pull_en
);

    localparam int CNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam logic [CFG_AW:0] NUM_PADS_W = (CFG_AW + 1)'(NUM_PADS);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_ACTIVE,
        ST_QUIESCE,
        ST_APPLY
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [CFG_AW-1:0]   pend_addr_reg, pend_addr_next;
    logic [7:0]          pend_data_reg, pend_data_next;
    logic [7:0]          cfg_q [NUM_PADS];
    logic [7:0]          cfg_next [NUM_PADS];
    logic [NUM_PADS-1:0] sync_reg [SYNC_STAGES-1];

    logic                cfg_ready_reg, cfg_err_reg, pwrup_done_reg;
    logic [NUM_PADS-1:0] dq_reg, enq_reg, enabq_reg, drv0_reg, drv1_reg, drv2_reg;
    logic [NUM_PADS-1:0] slew_reg, puq_reg, pd_reg, ppen_reg, zhl_reg, pull_en_reg, rx_reg;

    logic                fire, addr_ok, hold_wr, pend_load, commit;
    logic                active_next, quiet_next, hold_next;
    logic [NUM_PADS-1:0] hold_hit, commit_hit, forced_next, enq_next;

    assign fire    = cfg_valid & cfg_ready_reg;
    assign addr_ok = ({1'b0, cfg_addr} < NUM_PADS_W);
    assign hold_wr = (state_reg == ST_HOLD) & fire & addr_ok;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_load      = 1'b0;
        commit         = 1'b0;
        case (state_reg)
            ST_RESET: begin
                state_next = ST_HOLD;
                cnt_next   = CNT_W'(PWRUP_CYCLES - 1);
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ACTIVE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (fire && addr_ok) begin
                    state_next = ST_QUIESCE;
                    pend_load  = 1'b1;
                end
            end
            ST_QUIESCE: begin
                state_next = ST_APPLY;
                commit     = 1'b1;
            end
            ST_APPLY: begin
                state_next = ST_ACTIVE;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    assign pend_addr_next = pend_load ? cfg_addr : pend_addr_reg;
    assign pend_data_next = pend_load ? cfg_data : pend_data_reg;
    assign quiet_next     = (state_next == ST_QUIESCE) || (state_next == ST_APPLY);
    assign active_next    = (state_next == ST_ACTIVE) || quiet_next;
    assign hold_next      = (state_next == ST_RESET) || (state_next == ST_HOLD);

    // Pin registers are loaded from the post-update config so every pin changes on the
    // same edge as cfg_q; the pad under reconfiguration keeps its driver off meanwhile.
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
        assign hold_hit[gi]    = hold_wr && (cfg_addr == CFG_AW'(gi));
        assign commit_hit[gi]  = commit && (pend_addr_reg == CFG_AW'(gi));
        assign cfg_next[gi]    = hold_hit[gi]   ? cfg_data :
                                 commit_hit[gi] ? pend_data_reg : cfg_q[gi];
        assign forced_next[gi] = quiet_next && (pend_addr_next == CFG_AW'(gi));
        assign enq_next[gi]    = ~(tx_oe[gi] & cfg_next[gi][7] & active_next & ~forced_next[gi]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_RESET;
            cnt_reg        <= '0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            cfg_ready_reg  <= 1'b0;
            cfg_err_reg    <= 1'b0;
            pwrup_done_reg <= 1'b0;
            dq_reg         <= '1;
            enq_reg        <= '1;
            enabq_reg      <= '1;
            puq_reg        <= '1;
            zhl_reg        <= '1;
            pull_en_reg    <= '1;
            drv0_reg       <= '0;
            drv1_reg       <= '0;
            drv2_reg       <= '0;
            slew_reg       <= '0;
            pd_reg         <= '0;
            ppen_reg       <= '0;
            rx_reg         <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                cfg_q[i] <= '0;
            end
            for (int k = 0; k < SYNC_STAGES - 1; k++) begin
                sync_reg[k] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_addr_reg  <= pend_addr_next;
            pend_data_reg  <= pend_data_next;
            cfg_ready_reg  <= (state_next == ST_HOLD) || (state_next == ST_ACTIVE);
            cfg_err_reg    <= fire & ~addr_ok;
            pwrup_done_reg <= active_next;
            dq_reg         <= ~tx_data;
            enq_reg        <= enq_next;
            zhl_reg        <= {NUM_PADS{hold_next}};
            pull_en_reg    <= {NUM_PADS{hold_next}};
            sync_reg[0]    <= outi;
            for (int k = 1; k < SYNC_STAGES - 1; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
            for (int i = 0; i < NUM_PADS; i++) begin
                cfg_q[i]     <= cfg_next[i];
                drv0_reg[i]  <= cfg_next[i][0];
                drv1_reg[i]  <= cfg_next[i][1];
                drv2_reg[i]  <= cfg_next[i][2];
                slew_reg[i]  <= cfg_next[i][3];
                puq_reg[i]   <= ~cfg_next[i][4];
                pd_reg[i]    <= cfg_next[i][5] & ~cfg_next[i][4];
                enabq_reg[i] <= ~cfg_next[i][6];
                ppen_reg[i]  <= cfg_next[i][7];
                // Last synchroniser stage doubles as the input-enable gate.
                rx_reg[i]    <= sync_reg[SYNC_STAGES-2][i] & cfg_next[i][6];
            end
        end
    end

    assign cfg_ready     = cfg_ready_reg;
    assign cfg_err       = cfg_err_reg;
    assign pwrup_done    = pwrup_done_reg;
    assign dq            = dq_reg;
    assign enq           = enq_reg;
    assign enabq         = enabq_reg;
    assign drv0          = drv0_reg;
    assign drv1          = drv1_reg;
    assign drv2          = drv2_reg;
    assign prg_slew      = slew_reg;
    assign puq           = puq_reg;
    assign pd            = pd_reg;
    assign ppen          = ppen_reg;
    assign pwrupzhl      = zhl_reg;
    assign pwrup_pull_en = pull_en_reg;
    assign rx_data       = rx_reg;

endmodule

// File: tb/tb_hl_io_bank_ctrl.sv
// Self-checking bench for hl_io_bank_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based behavioural model.
module tb_hl_io_bank_ctrl;

    localparam int N = 4;
    localparam int S = 2;
    localparam int P = 16;
    localparam int AW = 3;
    localparam logic [54:0] RESET_ALL = {4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0,
                                         4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 3'b000};

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid, cfg_ready, cfg_err, pwrup_done;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;
    logic [N-1:0]  tx_data, tx_oe, rx_data, outi, dq, enq, enabq;
    logic [N-1:0]  drv0, drv1, drv2, prg_slew, puq, pd, ppen, pwrupzhl, pwrup_pull_en;
    logic [54:0]   dut_all;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int           cyc;
    int           busy;
    int           pa;
    logic [7:0]   pdat;
    logic [7:0]   cfg_m [N];
    logic [N-1:0] txd_q, txoe_q;
    logic         err_q;
    logic [N-1:0] hist [$];

    always #5 clock = ~clock;

    hl_io_bank_ctrl #(.NUM_PADS(N), .SYNC_STAGES(S), .PWRUP_CYCLES(P), .CFG_AW(AW)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .pwrup_done(pwrup_done),
        .tx_data(tx_data), .tx_oe(tx_oe), .rx_data(rx_data), .outi(outi),
        .dq(dq), .enq(enq), .enabq(enabq), .drv0(drv0), .drv1(drv1), .drv2(drv2),
        .prg_slew(prg_slew), .puq(puq), .pd(pd), .ppen(ppen),
        .pwrupzhl(pwrupzhl), .pwrup_pull_en(pwrup_pull_en)
    );

    assign dut_all = {dq, enq, enabq, drv2, drv1, drv0, prg_slew, puq, pd, ppen,
                      pwrupzhl, pwrup_pull_en, rx_data, cfg_ready, cfg_err, pwrup_done};

    function automatic bit m_active();
        return cyc > P;
    endfunction

    function automatic bit m_ready();
        return (cyc >= 1 && cyc <= P) || (cyc > P && busy == 0);
    endfunction

    function automatic logic [54:0] m_all();
        logic [N-1:0] e_enq, e_enab, e_d2, e_d1, e_d0, e_sl, e_puq, e_pd, e_pp, e_zhl, e_rx;
        for (int i = 0; i < N; i++) begin
            e_enq[i]  = ~(txoe_q[i] & cfg_m[i][7] & m_active() & !(busy > 0 && pa == i));
            e_enab[i] = ~cfg_m[i][6];
            e_d2[i]   = cfg_m[i][2];
            e_d1[i]   = cfg_m[i][1];
            e_d0[i]   = cfg_m[i][0];
            e_sl[i]   = cfg_m[i][3];
            e_puq[i]  = ~cfg_m[i][4];
            e_pd[i]   = cfg_m[i][5] & ~cfg_m[i][4];
            e_pp[i]   = cfg_m[i][7];
            e_rx[i]   = hist[0][i] & cfg_m[i][6];
        end
        e_zhl = (cyc <= P) ? '1 : '0;
        return {~txd_q, e_enq, e_enab, e_d2, e_d1, e_d0, e_sl, e_puq, e_pd, e_pp,
                e_zhl, e_zhl, e_rx, m_ready(), err_q, m_active()};
    endfunction

    task automatic m_reset();
        cyc = 0; busy = 0; pa = 0; pdat = '0; err_q = 1'b0;
        txd_q = '0; txoe_q = '0;
        for (int i = 0; i < N; i++) cfg_m[i] = '0;
        hist.delete();
        repeat (S) hist.push_back('0);
    endtask

    // Advance one clock; model updates with the inputs held during the cycle that ended.
    task automatic tick();
        bit rdy, act, fire;
        int a;
        rdy  = m_ready();
        act  = m_active();
        fire = cfg_valid && rdy;
        a    = int'(cfg_addr);
        @(posedge clock);
        err_q = fire && (a >= N);
        if (busy == 2) begin
            cfg_m[pa] = pdat;
            busy = 1;
        end else if (busy == 1) begin
            busy = 0;
        end
        if (fire && a < N) begin
            if (act) begin
                pa = a; pdat = cfg_data; busy = 2;
            end else begin
                cfg_m[a] = cfg_data;
            end
        end
        txd_q  = tx_data;
        txoe_q = tx_oe;
        hist.push_back(outi);
        if (hist.size() > S) void'(hist.pop_front());
        if (cyc <= P) cyc++;
        @(negedge clock);
    endtask

    task automatic write_cfg(input int a, input logic [7:0] d);
        int guard = 0;
        while (!m_ready() && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL write_wait addr %0d: ready not seen within %0d cycles", a, guard);
        end
        cfg_valid = 1'b1;
        cfg_addr  = AW'(a);
        cfg_data  = d;
        $display("cfg write addr %0d data %02h at cycle %0d", a, d, cyc);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (dut_all !== RESET_ALL) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", dut_all, RESET_ALL);
        end
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (pwrupzhl !== ((c <= 16) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL pwrupzhl cycle %0d got %h exp %h", c, pwrupzhl, (c <= 16) ? 4'hF : 4'h0);
            end
            checks++;
            if (pwrup_done !== (c >= 17) || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL pwrup_flags cycle %0d got done %b ready %b exp done %b ready 1",
                         c, pwrup_done, cfg_ready, c >= 17);
            end
            checks++;
            if (dut_all !== m_all()) begin
                errors++;
                $display("FAIL powerup_all cycle %0d got %h exp %h", c, dut_all, m_all());
            end
        end
    endtask

    task automatic test_tx();
        for (int i = 0; i < N; i++) write_cfg(i, 8'h80);
        tick(); tick();
        tx_data = 4'hA;
        tx_oe   = 4'hF;
        tick();
        checks++;
        if (dq !== 4'h5 || enq !== 4'h0) begin
            errors++;
            $display("FAIL tx_path got dq %h enq %h exp dq 5 enq 0", dq, enq);
        end
        checks++;
        if (dut_all !== m_all()) begin
            errors++;
            $display("FAIL tx_all got %h exp %h", dut_all, m_all());
        end
    endtask

    task automatic test_rx();
        tx_oe = '0;
        outi  = '0;
        write_cfg(0, 8'h00);
        write_cfg(1, 8'h40);
        write_cfg(2, 8'h00);
        write_cfg(3, 8'h00);
        tick(); tick(); tick();
        outi = 4'hF;
        tick();
        tick();
        checks++;
        if (rx_data !== 4'h2) begin
            errors++;
            $display("FAIL rx_path got %h exp 2", rx_data);
        end
        checks++;
        if (dut_all !== m_all()) begin
            errors++;
            $display("FAIL rx_all got %h exp %h", dut_all, m_all());
        end
    endtask

    task automatic test_reconfig();
        outi = '0;
        write_cfg(2, 8'hC3);
        tx_oe = 4'h4;
        tick(); tick(); tick();
        checks++;
        if (enq[2] !== 1'b0) begin
            errors++;
            $display("FAIL reconf_pre got enq %h exp enq[2]=0", enq);
        end
        cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 8'h85;
        $display("cfg write addr 2 data 85 at cycle %0d (pad driving)", cyc);
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (enq[2] !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reconf_t1 got enq %h ready %b exp enq[2]=1 ready 0", enq, cfg_ready);
        end
        tick();
        checks++;
        if (enq[2] !== 1'b1 || cfg_ready !== 1'b0 || {drv2[2], drv1[2], drv0[2]} !== 3'b101) begin
            errors++;
            $display("FAIL reconf_t2 got enq %h ready %b drv %b exp enq[2]=1 ready 0 drv 101",
                     enq, cfg_ready, {drv2[2], drv1[2], drv0[2]});
        end
        checks++;
        if (dut_all !== m_all()) begin
            errors++;
            $display("FAIL reconf_t2_all got %h exp %h", dut_all, m_all());
        end
        tick();
        checks++;
        if (enq[2] !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reconf_t3 got enq %h ready %b exp enq[2]=0 ready 1", enq, cfg_ready);
        end
    endtask

    task automatic test_bad_addr();
        cfg_valid = 1'b1; cfg_addr = 3'd5; cfg_data = 8'hFF;
        $display("cfg write addr 5 data ff at cycle %0d (out of range)", cyc);
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr got err %b ready %b exp err 1 ready 1", cfg_err, cfg_ready);
        end
        checks++;
        if (dut_all !== m_all()) begin
            errors++;
            $display("FAIL bad_addr_all got %h exp %h", dut_all, m_all());
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr_pulse got err %b exp 0", cfg_err);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            tx_data   = N'($urandom);
            tx_oe     = N'($urandom);
            outi      = N'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_addr  = AW'($urandom_range(0, 5));
            cfg_data  = 8'($urandom);
            tick();
            checks++;
            if (dut_all !== m_all()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random_all step %0d got %h exp %h", n, dut_all, m_all());
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid_apply();
        tx_oe = 4'hF;
        write_cfg(1, 8'hFF);
        tick();
        #2 reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (dut_all !== RESET_ALL) begin
            errors++;
            $display("FAIL reset_apply got %h exp %h", dut_all, RESET_ALL);
        end
        @(negedge clock);
        reset = 1'b0;
        tx_oe = '0;
        repeat (P + 2) tick();
        checks++;
        if ({drv2[1], drv1[1], drv0[1]} !== 3'b000 || ppen[1] !== 1'b0 || enabq[1] !== 1'b1
            || pwrup_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_clear got drv %b ppen %b enabq %b done %b exp 000 0 1 1",
                     {drv2[1], drv1[1], drv0[1]}, ppen[1], enabq[1], pwrup_done);
        end
        checks++;
        if (dut_all !== m_all()) begin
            errors++;
            $display("FAIL reset_after_all got %h exp %h", dut_all, m_all());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        tx_data = '0; tx_oe = '0; outi = '0;
        m_reset();
        test_reset();
        test_tx();
        test_rx();
        test_reconfig();
        test_bad_addr();
        test_random();
        test_reset_mid_apply();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
